// File: rtl/const_rom_reader.sv
// const_rom_reader: read sequencer for the four 8K x 8 constant EEPROM lanes.
// It turns a one-cycle request for H[idx] or K[idx] into a timed CE_N/OE_N
// read cycle. It then concatenates the four byte lanes into one 32-bit word.
// Optional feature macro: CONST_ROM_BURST_EN adds multi-word bursts.
// The burst ports are len and last.
module const_rom_reader #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned H_BASE      = 0,
  parameter int unsigned K_BASE      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        sel_k,
  input  logic [5:0]  idx,
`ifdef CONST_ROM_BURST_EN
  input  logic [5:0]  len,
  output logic        last,
`endif
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] data,
  output logic [12:0] a,
  output logic        ce_n,
  output logic        oe_n,
  output logic        we_n,
  input  logic [7:0]  io_1,
  input  logic [7:0]  io_2,
  input  logic [7:0]  io_3,
  input  logic [7:0]  io_4
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    ACCESS  = 3'd2,
    CAPTURE = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t      state, next_state;
  logic [7:0]  cnt;
  logic        range_err;
  logic [12:0] start_addr;
`ifdef CONST_ROM_BURST_EN
  logic [5:0]  rem;
  logic [6:0]  end_idx;
`endif

  // Request decode: this block computes the first EEPROM address.
  // It also flags indices that fall outside the selected table.
  always_comb begin
    start_addr = (sel_k ? 13'(K_BASE) : 13'(H_BASE)) + 13'(idx);
`ifdef CONST_ROM_BURST_EN
    end_idx   = {1'b0, idx} + {1'b0, len};
    range_err = sel_k ? (end_idx > 7'd63) : (end_idx > 7'd7);
`else
    range_err = !sel_k && (idx > 6'd7);
`endif
  end

  // State register: an async reset drops back to IDLE.
  // Because CE_N/OE_N decode from the state, a reset releases them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and the strobes decoded from the state.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    ce_n       = 1'b1;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    case (state)
      IDLE: begin
        if (req) next_state = range_err ? FIN : ADDR;
      end
      ADDR: begin
        busy       = 1'b1;
        next_state = ACCESS;
      end
      ACCESS: begin
        busy = 1'b1;
        ce_n = 1'b0;
        oe_n = 1'b0;
        if (cnt == 8'd0) next_state = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
`ifdef CONST_ROM_BURST_EN
        next_state = (rem != 6'd0) ? ADDR : FIN;
`else
        next_state = FIN;
`endif
      end
      FIN: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath block. It latches the address, runs the access-time counter and
  // captures the word. It raises done/err for exactly one cycle per result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a    <= '0;
      cnt  <= '0;
      data <= '0;
      done <= 1'b0;
      err  <= 1'b0;
`ifdef CONST_ROM_BURST_EN
      rem  <= '0;
      last <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
`ifdef CONST_ROM_BURST_EN
      last <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            if (range_err) begin
              done <= 1'b1;
              err  <= 1'b1;
`ifdef CONST_ROM_BURST_EN
              last <= 1'b1;
`endif
            end else begin
              a <= start_addr;
`ifdef CONST_ROM_BURST_EN
              rem <= len;
`endif
            end
          end
        end
        ADDR: begin
          cnt <= 8'(WAIT_CYCLES - 1);
        end
        ACCESS: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
        end
        CAPTURE: begin
          data <= {io_1, io_2, io_3, io_4};
          done <= 1'b1;
`ifdef CONST_ROM_BURST_EN
          last <= (rem == 6'd0);
          if (rem != 6'd0) begin
            rem <= rem - 6'd1;
            a   <= a + 13'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_const_rom_reader.sv
// Self-checking testbench for const_rom_reader. A small EEPROM model answers
// on the shared address bus. Each test task checks its own results inline.
module tb_const_rom_reader;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n, req, sel_k;
  logic [5:0]  idx;
  logic        busy, done, err, ce_n, oe_n, we_n;
  logic [31:0] data;
  logic [12:0] a;
  logic [7:0]  io_1, io_2, io_3, io_4;
`ifdef CONST_ROM_BURST_EN
  logic [5:0]  len;
  logic        last;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rom [0:71];
  logic [31:0] rom_word;

  const_rom_reader #(.WAIT_CYCLES(W), .H_BASE(0), .K_BASE(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sel_k(sel_k), .idx(idx),
`ifdef CONST_ROM_BURST_EN
    .len(len), .last(last),
`endif
    .busy(busy), .done(done), .err(err), .data(data), .a(a),
    .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n),
    .io_1(io_1), .io_2(io_2), .io_3(io_3), .io_4(io_4)
  );

  always #5 clk = ~clk;

  // EEPROM bank model: the stored word at the presented address.
  always_comb begin
    rom_word = (a < 13'd72) ? rom[a] : 32'h0;
    io_1 = rom_word[31:24];
    io_2 = rom_word[23:16];
    io_3 = rom_word[15:8];
    io_4 = rom_word[7:0];
  end

  initial begin
    for (int i = 0; i < 72; i++) rom[i] = 32'h1000_0000 + i;
    rom[0] = 32'h6a09e667; rom[1] = 32'hbb67ae85; rom[2] = 32'h3c6ef372;
    rom[3] = 32'ha54ff53a; rom[4] = 32'h510e527f; rom[5] = 32'h9b05688c;
    rom[6] = 32'h1f83d9ab; rom[7] = 32'h5be0cd19;
    rom[8] = 32'h428a2f98; rom[71] = 32'hc67178f2;
  end

  // Issues one request and follows it to its DONE.
  // lat is the index of the cycle with DONE high, counting from 1 after the sampling edge.
  task automatic run_req(input logic s, input logic [5:0] ix, input logic [5:0] ln,
                         input bit pulse, output int lat, output int ce_low,
                         output int oe_low, output int ndone, output logic [31:0] d_at,
                         output logic e_at, output logic [12:0] a_at, output logic l_at,
                         output logic busy_c1);
    lat = 0; ce_low = 0; oe_low = 0; ndone = 0;
    d_at = 'x; e_at = 1'bx; a_at = 'x; l_at = 1'bx; busy_c1 = 1'bx;
    @(negedge clk);
    req = 1'b1; sel_k = s; idx = ix;
`ifdef CONST_ROM_BURST_EN
    len = ln;
`else
    if (ln != 6'd0) $display("[TB] note: len ignored without burst support");
`endif
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) busy_c1 = busy;
      if (!ce_n) ce_low++;
      if (!oe_n) oe_low++;
      if (pulse && c == 3) req = 1'b1;
      else if (pulse && c == 4) req = 1'b0;
      if (done) begin
        ndone++; lat = c; d_at = data; e_at = err; a_at = a;
`ifdef CONST_ROM_BURST_EN
        l_at = last;
`endif
        if (pulse) req = 1'b1;
        break;
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (!ce_n) ce_low++;
      if (!oe_n) oe_low++;
      if (done) ndone++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; sel_k = 1'b0; idx = '0;
`ifdef CONST_ROM_BURST_EN
    len = '0;
`endif
    #12;
    vectors++; if (a !== 13'd0) begin miscompares++; $display("[TB] FAIL reset_a: got %0h expected 0", a); end
    vectors++; if ({ce_n, oe_n, we_n} !== 3'b111) begin miscompares++; $display("[TB] FAIL reset_strobes: got %b expected 111", {ce_n, oe_n, we_n}); end
    vectors++; if ({busy, done, err} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, err}); end
    vectors++; if (data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 0", data); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_h_read();
    int lat, cl, ol, nd; logic [31:0] d; logic e, l, b1; logic [12:0] ad;
    run_req(1'b0, 6'd0, 6'd0, 1'b0, lat, cl, ol, nd, d, e, ad, l, b1);
    vectors++; if (lat !== 3 + W) begin miscompares++; $display("[TB] FAIL h0_latency: got %0d expected %0d", lat, 3 + W); end
    vectors++; if (d !== 32'h6a09e667) begin miscompares++; $display("[TB] FAIL h0_data: got %h expected 6a09e667", d); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("[TB] FAIL h0_err: got %b expected 0", e); end
    vectors++; if (ad !== 13'd0) begin miscompares++; $display("[TB] FAIL h0_addr: got %0d expected 0", ad); end
    vectors++; if (b1 !== 1'b1) begin miscompares++; $display("[TB] FAIL h0_busy: got %b expected 1", b1); end
    vectors++; if (we_n !== 1'b1) begin miscompares++; $display("[TB] FAIL we_n: got %b expected 1", we_n); end
  endtask

  task automatic test_k_read();
    int lat, cl, ol, nd; logic [31:0] d; logic e, l, b1; logic [12:0] ad;
    run_req(1'b1, 6'd0, 6'd0, 1'b0, lat, cl, ol, nd, d, e, ad, l, b1);
    vectors++; if (ad !== 13'd8) begin miscompares++; $display("[TB] FAIL k0_addr: got %0d expected 8", ad); end
    vectors++; if (d !== 32'h428a2f98) begin miscompares++; $display("[TB] FAIL k0_data: got %h expected 428a2f98", d); end
    run_req(1'b1, 6'd63, 6'd0, 1'b0, lat, cl, ol, nd, d, e, ad, l, b1);
    vectors++; if (ad !== 13'd71) begin miscompares++; $display("[TB] FAIL k63_addr: got %0d expected 71", ad); end
    vectors++; if (d !== 32'hc67178f2) begin miscompares++; $display("[TB] FAIL k63_data: got %h expected c67178f2", d); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("[TB] FAIL k63_err: got %b expected 0", e); end
  endtask

  task automatic test_range_error();
    int lat, cl, ol, nd; logic [31:0] d; logic e, l, b1; logic [12:0] ad;
    run_req(1'b0, 6'd8, 6'd0, 1'b0, lat, cl, ol, nd, d, e, ad, l, b1);
    vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL err_latency: got %0d expected 1", lat); end
    vectors++; if (e !== 1'b1) begin miscompares++; $display("[TB] FAIL err_flag: got %b expected 1", e); end
    vectors++; if (cl !== 0) begin miscompares++; $display("[TB] FAIL err_ce_low: got %0d expected 0", cl); end
    vectors++; if (d !== 32'hc67178f2) begin miscompares++; $display("[TB] FAIL err_data_hold: got %h expected c67178f2", d); end
    vectors++; if (ad !== 13'd71) begin miscompares++; $display("[TB] FAIL err_addr_hold: got %0d expected 71", ad); end
  endtask

  task automatic test_back_to_back();
    int lat, cl, ol, nd; logic [31:0] d; logic e, l, b1; logic [12:0] ad;
    run_req(1'b0, 6'd2, 6'd0, 1'b1, lat, cl, ol, nd, d, e, ad, l, b1);
    vectors++; if (nd !== 1) begin miscompares++; $display("[TB] FAIL busy_req_dones: got %0d expected 1", nd); end
    vectors++; if (cl !== W) begin miscompares++; $display("[TB] FAIL ce_low_cycles: got %0d expected %0d", cl, W); end
    vectors++; if (ol !== W) begin miscompares++; $display("[TB] FAIL oe_low_cycles: got %0d expected %0d", ol, W); end
    vectors++; if (d !== 32'h3c6ef372) begin miscompares++; $display("[TB] FAIL busy_req_data: got %h expected 3c6ef372", d); end
  endtask

  task automatic test_reset_mid_access();
    int lat, cl, ol, nd; logic [31:0] d; logic e, l, b1; logic [12:0] ad;
    @(negedge clk);
    req = 1'b1; sel_k = 1'b0; idx = 6'd3;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (ce_n !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_access_ce: got %b expected 0", ce_n); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({ce_n, oe_n} !== 2'b11) begin miscompares++; $display("[TB] FAIL async_release: got %b expected 11", {ce_n, oe_n}); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL async_busy: got %b expected 0", busy); end
    vectors++; if (data !== 32'h0) begin miscompares++; $display("[TB] FAIL async_data: got %h expected 0", data); end
    @(negedge clk) rst_n = 1'b1;
    run_req(1'b0, 6'd7, 6'd0, 1'b0, lat, cl, ol, nd, d, e, ad, l, b1);
    vectors++; if (d !== 32'h5be0cd19) begin miscompares++; $display("[TB] FAIL h7_data: got %h expected 5be0cd19", d); end
    vectors++; if (lat !== 3 + W) begin miscompares++; $display("[TB] FAIL h7_latency: got %0d expected %0d", lat, 3 + W); end
  endtask

`ifdef CONST_ROM_BURST_EN
  task automatic test_burst();
    int lat, cl, ol, nd, words; logic [31:0] d; logic e, l, b1; logic [12:0] ad;
    bit seen_last;
    @(negedge clk);
    req = 1'b1; sel_k = 1'b0; idx = 6'd0; len = 6'd7;
    @(posedge clk);
    #1 req = 1'b0;
    words = 0; seen_last = 1'b0;
    for (int c = 1; c <= 200 && !seen_last; c++) begin
      @(negedge clk);
      if (done) begin
        vectors++;
        if (data !== rom[words]) begin miscompares++; $display("[TB] FAIL burst_data[%0d]: got %h expected %h", words, data, rom[words]); end
        vectors++;
        if (last !== (words == 7)) begin miscompares++; $display("[TB] FAIL burst_last[%0d]: got %b expected %b", words, last, words == 7); end
        words++;
        if (last || words >= 8) seen_last = 1'b1;
      end
    end
    vectors++; if (words !== 8) begin miscompares++; $display("[TB] FAIL burst_count: got %0d expected 8", words); end
    repeat (3) @(negedge clk);
    run_req(1'b0, 6'd4, 6'd4, 1'b0, lat, cl, ol, nd, d, e, ad, l, b1);
    vectors++; if ({e, l} !== 2'b11) begin miscompares++; $display("[TB] FAIL burst_err: got %b expected 11", {e, l}); end
    vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL burst_err_latency: got %0d expected 1", lat); end
  endtask
`endif

  initial begin
    test_reset();
    test_h_read();
    test_k_read();
    test_range_error();
    test_back_to_back();
    test_reset_mid_access();
`ifdef CONST_ROM_BURST_EN
    test_burst();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
